// File: rtl/sfifo_pkt_mem.sv
// Single-write, asynchronous-read storage array for the packet FIFO.
// Each entry holds a data word plus its end-of-packet flag.
module sfifo_pkt_mem #(
  parameter int DW = 9,
  parameter int AW = 4
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [0:(1<<AW)-1];

  always_ff @(posedge i_clk) begin
    if (i_we)
      r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sfifo_pkt.sv
// Synchronous packet FIFO with speculative write and commit/rollback.
// The reader only ever sees words of packets that were committed with i_wr_last.
module sfifo_pkt #(
  parameter int BW     = 8,
  parameter int LGFLEN = 4,
  parameter int LGPKT  = LGFLEN
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_wr,
  input  logic [BW-1:0]     i_data,
  input  logic              i_wr_last,
  input  logic              i_wr_abort,
  output logic              o_full,
  output logic [LGFLEN:0]   o_fill,
  output logic              o_overflow,
  input  logic              i_rd,
  output logic [BW-1:0]     o_data,
  output logic              o_last,
  output logic              o_empty,
  output logic [LGFLEN:0]   o_avail,
  output logic [LGPKT-1:0]  o_npkts
);

  localparam int FLEN = 1 << LGFLEN;
  localparam logic [LGFLEN:0] FLEN_V = (LGFLEN+1)'(FLEN);

  logic [LGFLEN:0]  r_wr_addr, r_wr_commit, r_rd_addr;
  logic [LGFLEN:0]  r_fill, r_avail;
  logic [LGPKT-1:0] r_npkts;
  logic             r_full, r_empty, r_overflow;

  logic             w_wr, w_rd, w_abort, w_commit, w_rd_last;
  logic [BW:0]      w_mem_rdata;
  logic [LGFLEN:0]  w_wr_addr_nxt, w_commit_nxt, w_rd_addr_nxt;
  logic [LGFLEN:0]  w_fill_nxt, w_avail_nxt;
  logic [LGPKT-1:0] w_npkts_nxt;

  // Full and overflow are the registered values, so a write blocked in the
  // same cycle as a freeing read still counts as an overflow.
  assign w_wr      = i_wr && !r_full && !r_overflow && !i_wr_abort;
  assign w_abort   = i_wr_abort || (r_overflow && i_wr && i_wr_last);
  assign w_commit  = w_wr && i_wr_last;
  assign w_rd      = i_rd && !r_empty;
  assign w_rd_last = w_rd && w_mem_rdata[BW];

  sfifo_pkt_mem #(
    .DW (BW+1),
    .AW (LGFLEN)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (w_wr),
    .i_waddr (r_wr_addr[LGFLEN-1:0]),
    .i_wdata ({i_wr_last, i_data}),
    .i_raddr (r_rd_addr[LGFLEN-1:0]),
    .o_rdata (w_mem_rdata)
  );

  always_comb begin
    w_wr_addr_nxt = r_wr_addr;
    w_commit_nxt  = r_wr_commit;
    w_rd_addr_nxt = r_rd_addr;
    w_npkts_nxt   = r_npkts;
    if (w_abort)
      w_wr_addr_nxt = r_wr_commit;
    else if (w_wr)
      w_wr_addr_nxt = r_wr_addr + 1'b1;
    if (w_commit)
      w_commit_nxt = r_wr_addr + 1'b1;
    if (w_rd)
      w_rd_addr_nxt = r_rd_addr + 1'b1;
    // A commit and a last-word read in the same cycle cancel out.
    case ({w_commit, w_rd_last})
      2'b10:   w_npkts_nxt = r_npkts + 1'b1;
      2'b01:   w_npkts_nxt = r_npkts - 1'b1;
      default: w_npkts_nxt = r_npkts;
    endcase
    w_fill_nxt  = w_wr_addr_nxt - w_rd_addr_nxt;
    w_avail_nxt = w_commit_nxt - w_rd_addr_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_addr   <= '0;
      r_wr_commit <= '0;
      r_rd_addr   <= '0;
      r_fill      <= '0;
      r_avail     <= '0;
      r_npkts     <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_overflow  <= 1'b0;
    end else begin
      r_wr_addr   <= w_wr_addr_nxt;
      r_wr_commit <= w_commit_nxt;
      r_rd_addr   <= w_rd_addr_nxt;
      r_fill      <= w_fill_nxt;
      r_avail     <= w_avail_nxt;
      r_npkts     <= w_npkts_nxt;
      r_full      <= (w_fill_nxt == FLEN_V);
      r_empty     <= (w_avail_nxt == '0);
      if (w_abort)
        r_overflow <= 1'b0;
      else if (i_wr && r_full)
        r_overflow <= 1'b1;
    end
  end

  assign o_full     = r_full;
  assign o_fill     = r_fill;
  assign o_overflow = r_overflow;
  assign o_empty    = r_empty;
  assign o_avail    = r_avail;
  assign o_npkts    = r_npkts;
  assign o_data     = w_mem_rdata[BW-1:0];
  assign o_last     = w_mem_rdata[BW];

endmodule

// File: tb/tb_sfifo_pkt.sv
// Scoreboard bench for sfifo_pkt: directed scenarios followed by random traffic,
// checked against a queue-based packet model.
module tb_sfifo_pkt;

  localparam int BW     = 8;
  localparam int LGFLEN = 4;
  localparam int LGPKT  = 4;
  localparam int FLEN   = 16;

  logic              i_clk = 1'b0;
  logic              i_reset = 1'b1;
  logic              i_wr = 1'b0, i_wr_last = 1'b0, i_wr_abort = 1'b0, i_rd = 1'b0;
  logic [BW-1:0]     i_data = '0;
  logic              o_full, o_overflow, o_last, o_empty;
  logic [LGFLEN:0]   o_fill, o_avail;
  logic [LGPKT-1:0]  o_npkts;
  logic [BW-1:0]     o_data;

  sfifo_pkt #(.BW(BW), .LGFLEN(LGFLEN), .LGPKT(LGPKT)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_wr       (i_wr),
    .i_data     (i_data),
    .i_wr_last  (i_wr_last),
    .i_wr_abort (i_wr_abort),
    .o_full     (o_full),
    .o_fill     (o_fill),
    .o_overflow (o_overflow),
    .i_rd       (i_rd),
    .o_data     (o_data),
    .o_last     (o_last),
    .o_empty    (o_empty),
    .o_avail    (o_avail),
    .o_npkts    (o_npkts)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  // Reference model: committed words, speculative words, scoreboard of words to be read.
  logic [BW:0] cq[$];
  logic [BW:0] pq[$];
  logic [BW:0] exp_q[$];
  bit          ovf = 0;

  function automatic int count_last();
    int c = 0;
    foreach (cq[i]) if (cq[i][BW]) c++;
    return c;
  endfunction

  always @(posedge i_clk) begin : model
    bit mfull, rd, ab, wr;
    if (i_reset) begin
      cq.delete(); pq.delete(); exp_q.delete(); ovf = 0;
    end else begin
      mfull = (cq.size() + pq.size()) == FLEN;
      rd    = i_rd && (cq.size() != 0);
      ab    = i_wr_abort || (ovf && i_wr && i_wr_last);
      wr    = i_wr && !mfull && !ovf && !i_wr_abort;
      if (rd) void'(cq.pop_front());
      if (ab) begin
        pq.delete();
        ovf = 0;
      end else if (wr) begin
        pq.push_back({i_wr_last, i_data});
        if (i_wr_last) begin
          foreach (pq[i]) begin
            cq.push_back(pq[i]);
            exp_q.push_back(pq[i]);
          end
          pq.delete();
        end
      end else if (i_wr && mfull) begin
        ovf = 1;
      end
    end
  end

  // Monitor: status every cycle, data whenever the DUT hands out a word.
  always @(negedge i_clk) begin : monitor
    int ef, ea, en;
    logic [BW:0] w;
    if (chk_en) begin
      ef = cq.size() + pq.size();
      ea = cq.size();
      en = count_last();
      n_cmp++;
      if (o_fill !== ef[LGFLEN:0] || o_avail !== ea[LGFLEN:0] || o_npkts !== en[LGPKT-1:0] ||
          o_empty !== (ea == 0) || o_full !== (ef == FLEN) || o_overflow !== ovf) begin
        n_bad++;
        $display("FAIL status t=%0t: got fill=%0d avail=%0d npkts=%0d empty=%0b full=%0b ovf=%0b, want fill=%0d avail=%0d npkts=%0d empty=%0b full=%0b ovf=%0b",
                 $time, o_fill, o_avail, o_npkts, o_empty, o_full, o_overflow,
                 ef, ea, en, (ea == 0), (ef == FLEN), ovf);
      end
      if (!i_reset && i_rd && !o_empty) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL read_unexpected t=%0t: got last=%0b data=%02h, want no readable word", $time, o_last, o_data);
        end else begin
          w = exp_q.pop_front();
          if ({o_last, o_data} !== w) begin
            n_bad++;
            $display("FAIL read_data t=%0t: got last=%0b data=%02h, want last=%0b data=%02h",
                     $time, o_last, o_data, w[BW], w[BW-1:0]);
          end
        end
      end
    end
  end

  task automatic cyc(input bit wr, input logic [BW-1:0] d, input bit last, input bit ab, input bit rd);
    i_wr = wr; i_data = d; i_wr_last = last; i_wr_abort = ab; i_rd = rd;
    @(posedge i_clk); #1;
    i_wr = 0; i_wr_last = 0; i_wr_abort = 0; i_rd = 0;
  endtask

  task automatic do_reset();
    i_reset = 1;
    @(posedge i_clk); #1;
    i_reset = 0;
  endtask

  task automatic drain();
    int k = 0;
    while (!o_empty && k < 64) begin
      cyc(0, 8'h00, 0, 0, 1);
      k++;
    end
    n_cmp++;
    if (!o_empty) begin
      n_bad++;
      $display("FAIL drain_timeout: got o_empty=%0b after %0d reads, want 1", o_empty, k);
    end
  endtask

  initial begin
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    chk_en = 1;
    i_reset = 0;

    // Commit of a three-word packet, then read it back.
    cyc(1, 8'h11, 0, 0, 0);
    cyc(1, 8'h22, 0, 0, 0);
    cyc(1, 8'h33, 1, 0, 0);
    cyc(0, 8'h00, 0, 0, 0);
    repeat (3) cyc(0, 8'h00, 0, 0, 1);
    cyc(0, 8'h00, 0, 0, 0);

    // Abort discards only the uncommitted packet.
    cyc(1, 8'hA0, 1, 0, 0);
    cyc(1, 8'hB0, 0, 0, 0);
    cyc(1, 8'hB1, 0, 0, 0);
    cyc(0, 8'h00, 0, 1, 0);
    cyc(0, 8'h00, 0, 0, 1);
    cyc(1, 8'hC0, 1, 0, 0);
    drain();

    // Overflow: a packet longer than the FIFO is dropped and rolled back.
    for (int i = 0; i < FLEN + 2; i++) cyc(1, 8'(8'h40 + i), 0, 0, 0);
    cyc(1, 8'h7F, 1, 0, 0);
    cyc(0, 8'h00, 0, 0, 0);
    cyc(1, 8'h81, 1, 0, 0);
    drain();

    // Wrap-around with concurrent reads.
    for (int i = 0; i < 40; i++) cyc(1, 8'(i), 1, 0, i > 0);
    drain();

    // Commit and last-word read in the same cycle.
    cyc(1, 8'h5A, 1, 0, 0);
    cyc(1, 8'h5B, 1, 0, 1);
    cyc(0, 8'h00, 0, 0, 0);
    drain();

    // Reset with committed and speculative data present.
    cyc(1, 8'h01, 1, 0, 0);
    cyc(1, 8'h02, 0, 0, 0);
    cyc(1, 8'h03, 0, 0, 0);
    do_reset();
    cyc(1, 8'h44, 0, 0, 0);
    cyc(1, 8'h45, 1, 0, 0);
    drain();

    // Random traffic in phases of differing read pressure.
    for (int ph = 0; ph < 3; ph++) begin
      for (int n = 0; n < 1000; n++) begin
        bit wr, last, ab, rd;
        wr   = $urandom_range(99) < 65;
        last = $urandom_range(99) < 20;
        ab   = $urandom_range(99) < 4;
        rd   = $urandom_range(99) < (ph == 0 ? 50 : (ph == 1 ? 10 : 85));
        if ($urandom_range(999) == 0) do_reset();
        else cyc(wr, 8'($urandom), last, ab, rd);
      end
    end
    cyc(0, 8'h00, 0, 1, 0);
    drain();

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL leftover: got %0d unread expected words, want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
